sum_of_squares_cal: RTL and testbench

SUM_OF_SQUARES_CAL -- requirements
Module: sum_of_squares_cal

---
 rtl/sum_of_squares_cal.sv | 102 ++++++++++
 tb/tb_sum_of_squares_cal.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_of_squares_cal.sv
//============================================================================
// Module  : sum_of_squares_cal
// Brief   : Computes |I|^2 + |Q|^2 with one shift-add step per cycle.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module sum_of_squares_cal #(
    parameter int DATA_WIDTH = 71
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inputValid,
    output logic                      inputReady,
    input  logic [DATA_WIDTH-1:0]     dataInI,
    input  logic [DATA_WIDTH-1:0]     dataInQ,
    output logic                      outputValid,
    output logic [2*DATA_WIDTH-1:0]   outputData
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        SUM      = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   abs_i;
    logic [DATA_WIDTH-1:0]   abs_q;
    logic [DATA_WIDTH-1:0]   mag_i;
    logic [DATA_WIDTH-1:0]   mag_q;
    logic [PROD_W-1:0]       acc_i;
    logic [PROD_W-1:0]       acc_q;
    logic [PROD_W-1:0]       part_i;
    logic [PROD_W-1:0]       part_q;
    logic [CNT_W-1:0]        bit_cnt;

    // Unsigned negation maps the most negative input to 2^(DATA_WIDTH-1) exactly.
    assign mag_i = dataInI[DATA_WIDTH-1] ? -dataInI : dataInI;
    assign mag_q = dataInQ[DATA_WIDTH-1] ? -dataInQ : dataInQ;

    assign part_i = {{DATA_WIDTH{1'b0}}, abs_i} << bit_cnt;
    assign part_q = {{DATA_WIDTH{1'b0}}, abs_q} << bit_cnt;

    assign inputReady = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            abs_i       <= '0;
            abs_q       <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
            bit_cnt     <= '0;
            outputValid <= 1'b0;
            outputData  <= '0;
        end else begin
            outputValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (inputValid) begin
                        abs_i   <= mag_i;
                        abs_q   <= mag_q;
                        acc_i   <= '0;
                        acc_q   <= '0;
                        bit_cnt <= '0;
                        state   <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    if (abs_i[bit_cnt]) begin
                        acc_i <= acc_i + part_i;
                    end
                    if (abs_q[bit_cnt]) begin
                        acc_q <= acc_q + part_q;
                    end
                    // Counter parks on the last bit; it is cleared on the next acceptance.
                    if (bit_cnt == LAST_BIT) begin
                        state <= SUM;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                SUM: begin
                    outputData  <= acc_i + acc_q;
                    outputValid <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sum_of_squares_cal.sv
//============================================================================
// Module  : tb_sum_of_squares_cal
// Brief   : Scoreboard bench for sum_of_squares_cal (values, latency, reset abort).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_sum_of_squares_cal;

    localparam int DW = 71;
    localparam int PW = 2 * DW;

    typedef struct {
        logic [PW-1:0] data;
        int            acc_edge;
    } item_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           inputValid = 1'b0;
    logic           inputReady;
    logic [DW-1:0]  dataInI = '0;
    logic [DW-1:0]  dataInQ = '0;
    logic           outputValid;
    logic [PW-1:0]  outputData;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    last_out = 0;
    int    prev_out = 0;
    item_t sb[$];

    sum_of_squares_cal #(.DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .inputValid (inputValid),
        .inputReady (inputReady),
        .dataInI    (dataInI),
        .dataInQ    (dataInQ),
        .outputValid(outputValid),
        .outputData (outputData)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
        logic signed [PW-1:0] si;
        logic signed [PW-1:0] sq;
        logic [PW-1:0] mi;
        logic [PW-1:0] mq;
        si = i;
        sq = q;
        mi = (si < 0) ? -si : si;
        mq = (sq < 0) ? -sq : sq;
        return mi * mi + mq * mq;
    endfunction

    // Output monitor: every pulse must match the oldest outstanding sample.
    always @(negedge clock) begin
        if (outputValid) begin
            prev_out = last_out;
            last_out = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", PW'(outputValid), '0);
            end else begin
                chk("data", outputData, sb[0].data);
                chk("latency", PW'(cyc - sb[0].acc_edge), PW'(DW + 1));
                void'(sb.pop_front());
            end
        end
    end

    // Leaves inputValid high on return so that a following send is back-to-back.
    task automatic send(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clock);
        inputValid = 1'b1;
        dataInI    = i;
        dataInQ    = q;
        while (!inputReady && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!inputReady) begin
            chk("accept_timeout", PW'(inputReady), PW'(1));
        end else begin
            acc = cyc + 1;
            sb.push_back('{model(i, q), acc});
        end
        @(posedge clock);
    endtask

    task automatic idle_input();
        @(negedge clock);
        inputValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("drain", PW'(sb.size()), '0);
    endtask

    initial begin
        int a1, a2;
        logic signed [DW-1:0] ri, rq;
        logic signed [DW-1:0] most_neg;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", PW'(outputValid), '0);
        chk("rst_data", outputData, '0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_rst", PW'(inputReady), PW'(1));

        // 3/4 -> 25, busy while multiplying, result held afterwards
        send(3, 4, a1);
        idle_input();
        chk("busy_ready", PW'(inputReady), '0);
        drain();
        repeat (20) @(negedge clock);
        chk("hold", outputData, PW'(25));

        most_neg = {1'b1, {(DW-1){1'b0}}};
        send(most_neg, most_neg, a1);
        idle_input();
        drain();
        chk("max_topbit", PW'(outputData[PW-1]), PW'(1));

        send(0, 0, a1);
        idle_input();
        drain();

        // Valid held with 7/7 during the first computation: accepted right after SUM.
        send(-1, 1, a1);
        send(7, 7, a2);
        idle_input();
        drain();
        chk("hold_accept_gap", PW'(a2 - a1), PW'(DW + 2));

        // Reset mid-computation aborts without a pulse.
        send(5, -12, a1);
        idle_input();
        while (cyc < a1 + 29) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        chk("abort_data", outputData, '0);
        chk("abort_ready", PW'(inputReady), PW'(1));
        repeat (90) @(negedge clock);
        chk("abort_no_valid", PW'(outputValid), '0);
        send(5, -12, a1);
        idle_input();
        drain();

        // Back-to-back samples
        send(5, -12, a1);
        send(-8, 15, a2);
        idle_input();
        drain();
        chk("b2b_out_gap", PW'(last_out - prev_out), PW'(DW + 2));

        for (int k = 0; k < 4; k++) begin
            ri = {$urandom, $urandom, $urandom};
            rq = {$urandom, $urandom, $urandom};
            send(ri, rq, a1);
        end
        idle_input();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
